mul_issue_wb: RTL and testbench
===============================

Name: mul_issue_wb

Overview:
- Sits around the integer multiply execution unit, both upstream and downstream of it.
- Upstream: buffers decoded M-extension multiply ops from the stage-3 dispatcher in a small FIFO and launches them one at a time with a start/ready handshake.
- Downstream: captures the 128-bit product, selects and sign-extends the architectural 64-bit result per op, and presents it with its destination tag to writeback under a valid/ready handshake.
- Supports pipeline flush.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
TAG_W, 5, destination-register/ROB tag width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  kill all queued and in-flight ops
in_valid  input  1  dispatcher offers an op
in_ready  output  1  FIFO can accept
in_op1  input  64  operand 1
in_op2  input  64  operand 2
in_sel  input  3  op select (MUL, MULH, MULHSU, MULHU, MULW from instr_op.sv)
in_tag  input  TAG_W  destination tag
mul_start  output  1  one-cycle launch pulse to multiply unit
mul_op1  output  64  operand 1 to unit, held from start until product capture
mul_op2  output  64  operand 2 to unit, held likewise
mul_sel  output  3  select to unit, held likewise
mul_ready  input  1  unit product valid (one-cycle pulse)
mul_prod  input  128  full product from unit
out_valid  output  1  result available
out_ready  input  1  writeback accepts
out_result  output  64  architectural result
out_tag  output  TAG_W  tag of result

Behaviour:
- Reset, rst=1 at a clk edge:
  - FIFO empty; state IDLE.
  - in_ready=1; mul_start=0; out_valid=0.
  - mul_op1/mul_op2/out_result=0; mul_sel=0; out_tag=0.
  - Reset mid-operation abandons everything; a later mul_ready pulse is ignored.
- FIFO:
  - Push when in_valid&&in_ready.
  - in_ready = !full, combinational from registered count; no same-cycle push-through when full.
  - Pointers wrap modulo DEPTH.
  - Count tracks simultaneous push and pop correctly.
  - No bypass: an op pushed into an empty FIFO at edge N is popped at edge N+1 at the earliest.
- State machine, registered:
  - IDLE:
    - If FIFO non-empty and !flush: pop head; load mul_op1/op2/sel and internal tag; mul_start=1 for the next cycle only; ->BUSY.
  - BUSY:
    - Hold operands.
    - On mul_ready: capture formatted result into out_result/out_tag; out_valid=1; ->HOLD.
    - mul_ready in the same cycle as mul_start is legal and captured.
  - HOLD:
    - out_valid, out_result and out_tag are stable until out_ready.
    - On out_valid&&out_ready: out_valid=0.
    - If the FIFO is non-empty, pop and launch in the same edge (->BUSY). Otherwise ->IDLE.
    - Back-to-back throughput: one op per (unit latency + 1) cycles.
  - DRAIN:
    - Entered on flush while BUSY.
    - Waits for mul_ready, discards the product, ->IDLE.
    - in_ready stays valid (pushes allowed).
  - mul_ready outside BUSY/DRAIN is ignored.
- Formatting:
  - MUL: prod[63:0].
  - MULH, MULHSU, MULHU: prod[127:64].
  - MULW: sign-extend prod[31:0] to 64.
  - Unused encodings 5-7: result 0, completes normally.
- Flush, flush=1 at edge:
  - FIFO emptied, including any same-cycle push (push dropped).
  - out_valid cleared.
  - From BUSY ->DRAIN. From HOLD or IDLE ->IDLE.
  - No pop or start that cycle.
  - Flush has priority over every other event except rst.
- Latency, empty FIFO and IDLE:
  - Push at edge N; mul_start high in cycle N+1.
  - Unit pulses mul_ready at edge M; out_valid high from M.

Test Plan:
- Reset then single MUL: op1=7, op2=-3 (0xFFFF_FFFF_FFFF_FFFD), stub returns prod=sign-ext -21 -> out_result=0xFFFF_FFFF_FFFF_FFEB, out_tag=in_tag, mul_start exactly one cycle after push.
- MULHU: op1=op2=0xFFFF_FFFF_FFFF_FFFF, prod=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 -> out_result=0xFFFF_FFFF_FFFF_FFFE. MULW with prod low word 0x8000_0000 -> out_result=0xFFFF_FFFF_8000_0000.
- Fill: push 5 ops with DEPTH=4 while the unit stalls -> in_ready low after the FIFO holds 4 plus 1 in flight. Results emerge in push order with correct tags; pointers wrap cleanly over 12 ops.
- Writeback backpressure: out_ready=0 for 10 cycles -> out_result/out_tag stable, no new mul_start. Raising out_ready causes a same-edge launch of the next op.
- Flush while BUSY: then mul_ready pulses -> no out_valid. The next pushed op completes with its own tag. A flush coincident with a push drops that push.
- rst asserted in HOLD with 3 queued ops -> all outputs at reset values next cycle; a following stray mul_ready produces nothing.

Source files
------------

// File: rtl/mul_issue_wb.sv
// Purpose: queues decoded multiply ops, launches them one at a time into the
//   multiply unit, then formats the 128-bit product into a 64-bit writeback result.
// Latency: a push into an empty queue gives mul_start one cycle later; the result
//   is valid from the edge that samples mul_ready.
// Backpressure: in_ready drops when the queue is full. A held result (out_ready low)
//   blocks the next launch.
// Ports: clk/rst (sync, active-high); flush kills queued and in-flight ops;
//   in_* is the dispatcher valid/ready push; mul_* is the start/ready handshake with
//   the unit; out_* is the valid/ready result to writeback.
module mul_issue_wb #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_op1,
  input  logic [63:0]      in_op2,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_start,
  output logic [63:0]      mul_op1,
  output logic [63:0]      mul_op2,
  output logic [2:0]       mul_sel,
  input  logic             mul_ready,
  input  logic [127:0]     mul_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] SEL_MUL    = 3'd0;
  localparam logic [2:0] SEL_MULH   = 3'd1;
  localparam logic [2:0] SEL_MULHSU = 3'd2;
  localparam logic [2:0] SEL_MULHU  = 3'd3;
  localparam logic [2:0] SEL_MULW   = 3'd4;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

  state_t state, state_nxt;

  // Queue storage (data words need no reset; count/pointers gate all reads).
  logic [63:0]      q_op1 [DEPTH];
  logic [63:0]      q_op2 [DEPTH];
  logic [2:0]       q_sel [DEPTH];
  logic [TAG_W-1:0] q_tag [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             q_empty;
  logic             push, pop, capture, retire;
  logic [TAG_W-1:0] cur_tag;

  assign in_ready = (count != CNT_W'(DEPTH));
  assign q_empty  = (count == '0);
  // A flush drops a same-cycle push.
  assign push     = in_valid && in_ready && !flush;

  function automatic logic [63:0] fmt_result(input logic [2:0] sel, input logic [127:0] p);
    logic [63:0] r;
    r = '0;
    case (sel)
      SEL_MUL:                         r = p[63:0];
      SEL_MULH, SEL_MULHSU, SEL_MULHU: r = p[127:64];
      SEL_MULW:                        r = {{32{p[31]}}, p[31:0]};
      default:                         r = '0;
    endcase
    return r;
  endfunction

  // Next state and control strobes.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    if (flush) begin
      // A product arriving with the flush has nothing left to wait for.
      if (state == BUSY || state == DRAIN)
        state_nxt = mul_ready ? IDLE : DRAIN;
      else
        state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!q_empty) begin
            pop       = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (mul_ready) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            retire = 1'b1;
            if (!q_empty) begin
              pop       = 1'b1;
              state_nxt = BUSY;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        DRAIN: begin
          if (mul_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_op1[wr_ptr] <= in_op1;
      q_op2[wr_ptr] <= in_op2;
      q_sel[wr_ptr] <= in_sel;
      q_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Launch registers and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_start  <= 1'b0;
      mul_op1    <= '0;
      mul_op2    <= '0;
      mul_sel    <= '0;
      cur_tag    <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      mul_start <= pop;
      if (pop) begin
        mul_op1 <= q_op1[rd_ptr];
        mul_op2 <= q_op2[rd_ptr];
        mul_sel <= q_sel[rd_ptr];
        cur_tag <= q_tag[rd_ptr];
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid  <= 1'b1;
        out_result <= fmt_result(mul_sel, mul_prod);
        out_tag    <= cur_tag;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_wb.sv
module tb_mul_issue_wb;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_op1, in_op2;
  logic [2:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             mul_start;
  logic [63:0]      mul_op1, mul_op2;
  logic [2:0]       mul_sel;
  logic             mul_ready;
  logic [127:0]     mul_prod;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  int total = 0;
  int bad   = 0;

  mul_issue_wb #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_sel(in_sel), .in_tag(in_tag),
    .mul_start(mul_start), .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_sel(mul_sel),
    .mul_ready(mul_ready), .mul_prod(mul_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] s, input logic [TAG_W-1:0] t);
    chk("push_rdy", in_ready, 1);
    in_valid = 1'b1; in_op1 = a; in_op2 = b; in_sel = s; in_tag = t;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (mul_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("start_seen", mul_start, 1);
  endtask

  task automatic respond(input logic [127:0] p);
    mul_ready = 1'b1; mul_prod = p;
    tick();
    mul_ready = 1'b0; mul_prod = '0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] s,
                        input logic [TAG_W-1:0] t, input logic [127:0] p,
                        input logic [63:0] exp_res);
    push(a, b, s, t);
    wait_start();
    chk("op1", mul_op1, a);
    chk("op2", mul_op2, b);
    chk("sel", mul_sel, s);
    respond(p);
    chk("res_vld", out_valid, 1);
    chk("res", out_result, exp_res);
    chk("tag", out_tag, t);
    accept();
    chk("res_done", out_valid, 0);
  endtask

  function automatic logic [63:0] f_op1(input int i); return 64'(i * 3 + 1); endfunction
  function automatic logic [63:0] f_op2(input int i); return 64'(i + 2); endfunction
  function automatic logic [TAG_W-1:0] f_tag(input int i); return TAG_W'(i + 10); endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op1 = '0; in_op2 = '0;
    in_sel = '0; in_tag = '0; mul_ready = 1'b0; mul_prod = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_start", mul_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op1", mul_op1, 0);
    chk("rst_op2", mul_op2, 0);
    chk("rst_sel", mul_sel, 0);
    chk("rst_result", out_result, 0);
    chk("rst_tag", out_tag, 0);

    // Single MUL: 7 * -3, launch exactly one cycle after push, ready with start
    push(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 3'd0, 5'd5);
    chk("mul_nostart_yet", mul_start, 0);
    tick();
    chk("mul_start", mul_start, 1);
    chk("mul_op1", mul_op1, 64'd7);
    chk("mul_op2", mul_op2, 64'hFFFF_FFFF_FFFF_FFFD);
    respond({64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB});
    chk("mul_start_pulse", mul_start, 0);
    chk("mul_vld", out_valid, 1);
    chk("mul_res", out_result, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_tag", out_tag, 5'd5);
    accept();
    chk("mul_done", out_valid, 0);

    // Result formatting per select
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 5'd6,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(64'h8000_0000, 64'd1, 3'd4, 5'd7, 128'h8000_0000, 64'hFFFF_FFFF_8000_0000);
    run_op(64'd2, 64'd3, 3'd1, 5'd8, {64'h1234, 64'hDEAD_BEEF}, 64'h1234);
    run_op(64'd2, 64'd3, 3'd2, 5'd9, {64'hFFFF_FFFF_FFFF_FFF0, 64'h5}, 64'hFFFF_FFFF_FFFF_FFF0);
    run_op(64'd2, 64'd3, 3'd5, 5'd10, {64'h55, 64'hAA}, 64'd0);

    // Fill: 5 pushes while the unit stalls -> 1 in flight + 4 queued
    for (int i = 0; i < 5; i++) push(f_op1(i), f_op2(i), 3'd0, f_tag(i));
    chk("fill_full", in_ready, 0);
    chk("fill_nostart", mul_start, 0);
    // Drain 12 ops in order, refilling so the pointers wrap
    for (int i = 0; i < 12; i++) begin
      if (i > 0) wait_start();
      chk("ord_op1", mul_op1, f_op1(i));
      if (i >= 1 && i + 4 < 12) push(f_op1(i + 4), f_op2(i + 4), 3'd0, f_tag(i + 4));
      respond(128'(f_op1(i) * f_op2(i)));
      chk("ord_vld", out_valid, 1);
      chk("ord_res", out_result, f_op1(i) * f_op2(i));
      chk("ord_tag", out_tag, f_tag(i));
      accept();
    end
    chk("ord_empty_vld", out_valid, 0);

    // Writeback backpressure with an op queued behind
    push(64'd3, 64'd4, 3'd0, 5'd1);
    push(64'd9, 64'd9, 3'd0, 5'd2);
    wait_start();
    respond(128'd12);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_vld", out_valid, 1);
      chk("bp_res", out_result, 64'd12);
      chk("bp_tag", out_tag, 5'd1);
      chk("bp_nostart", mul_start, 0);
    end
    accept();
    chk("bp_launch", mul_start, 1);
    chk("bp_launch_op1", mul_op1, 64'd9);
    chk("bp_cleared", out_valid, 0);
    respond(128'd81);
    chk("bp2_res", out_result, 64'd81);
    chk("bp2_tag", out_tag, 5'd2);
    accept();

    // Flush while BUSY, then the late product is dropped
    push(64'd5, 64'd5, 3'd0, 5'd3);
    wait_start();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_vld", out_valid, 0);
    tick();
    respond(128'd25);
    chk("fl_drop", out_valid, 0);
    tick();
    chk("fl_drop2", out_valid, 0);
    run_op(64'd6, 64'd7, 3'd0, 5'd4, 128'd42, 64'd42);

    // Flush coincident with a push drops the push
    in_valid = 1'b1; in_op1 = 64'd1; in_op2 = 64'd1; in_sel = 3'd0; in_tag = 5'd11;
    flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("flpush_nostart", mul_start, 0);
      tick();
    end
    run_op(64'd8, 64'd8, 3'd0, 5'd12, 128'd64, 64'd64);

    // Reset in HOLD with 3 ops queued
    for (int i = 0; i < 4; i++) push(64'(i + 20), 64'd2, 3'd0, TAG_W'(i + 20));
    respond(128'd40);
    chk("hold_vld", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_vld", out_valid, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_start", mul_start, 0);
    chk("rst2_op1", mul_op1, 0);
    chk("rst2_result", out_result, 0);
    chk("rst2_tag", out_tag, 0);
    tick();
    chk("rst2_nostart", mul_start, 0);
    respond(128'd99);
    chk("stray_vld", out_valid, 0);
    tick();
    chk("stray_vld2", out_valid, 0);
    chk("stray_nostart", mul_start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
